// File: rtl/key_debouncer_pkg.sv
// Shared defaults (50 MHz timing) and helpers for the key debouncer.
// Repeat FSM encoding is only referenced when KEY_DEBOUNCER_REPEAT_EN is defined.
package key_debouncer_pkg;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

    localparam int unsigned DEF_CLK_HZ        = 50_000_000;
    localparam int unsigned DEF_N_KEYS        = 4;
    localparam int unsigned DEF_STABLE_CYCLES = ms_to_cycles(DEF_CLK_HZ, 20);
    localparam int unsigned DEF_REPEAT_DELAY  = ms_to_cycles(DEF_CLK_HZ, 500);
    localparam int unsigned DEF_REPEAT_PERIOD = ms_to_cycles(DEF_CLK_HZ, 100);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_PERIOD
    } rpt_state_e;

endpackage

// File: rtl/key_debouncer_if.sv
// Key bus: raw active-low buttons in, debounced level and edge pulses out.
interface key_debouncer_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;

    modport master (
        output key_n,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key_n,
        output key_level,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/key_debouncer_channel.sv
// One key: 2-flop synchronizer, stability counter, registered press/release pulses.
// Auto-repeat is compiled in only with KEY_DEBOUNCER_REPEAT_EN.
module key_debouncer_channel
    import key_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef KEY_DEBOUNCER_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned    CW       = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          sample;
    logic [CW-1:0] count;
    logic          accept;
    logic          press_edge;
    logic          release_edge;
    logic          repeat_fire;

    // Synchronizer idles at 1 (released) so reset never looks like a press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign sample       = ~sync2;
    assign accept       = (sample != key_level) && (count == CNT_LAST);
    assign press_edge   = accept & sample;
    assign release_edge = accept & ~sample;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            key_level <= 1'b0;
        end else if (sample == key_level) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            key_level <= sample;
            count     <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

`ifdef KEY_DEBOUNCER_REPEAT_EN
    localparam int unsigned   RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned   RW          = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    rpt_state_e    rpt_state;
    rpt_state_e    rpt_state_next;
    logic [RW-1:0] rpt_count;
    logic [RW-1:0] rpt_count_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rpt_state <= RPT_IDLE;
            rpt_count <= '0;
        end else begin
            rpt_state <= rpt_state_next;
            rpt_count <= rpt_count_next;
        end
    end

    // A level change restarts the timer; the release edge wins over a due repeat.
    always_comb begin
        rpt_state_next = rpt_state;
        rpt_count_next = rpt_count;
        repeat_fire    = 1'b0;
        if (accept) begin
            rpt_count_next = '0;
            rpt_state_next = sample ? RPT_DELAY : RPT_IDLE;
        end else begin
            case (rpt_state)
                RPT_DELAY: begin
                    if (rpt_count == DELAY_LAST) begin
                        repeat_fire    = 1'b1;
                        rpt_count_next = '0;
                        rpt_state_next = RPT_PERIOD;
                    end else begin
                        rpt_count_next = rpt_count + 1'b1;
                    end
                end
                RPT_PERIOD: begin
                    if (rpt_count == PERIOD_LAST) begin
                        repeat_fire    = 1'b1;
                        rpt_count_next = '0;
                    end else begin
                        rpt_count_next = rpt_count + 1'b1;
                    end
                end
                default: begin
                    rpt_count_next = '0;
                end
            endcase
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= press_edge | repeat_fire;
            key_release <= release_edge;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// N_KEYS independent debounced push-button channels behind a key_debouncer_if bus.
// Optional auto-repeat of key_press is enabled by defining KEY_DEBOUNCER_REPEAT_EN.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned N_KEYS        = DEF_N_KEYS,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic            clock,
    input  logic            reset_n,
    key_debouncer_if.slave  keys
);

    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] release_p;

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << 24) || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_debouncer: parameter out of range");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_channel
        key_debouncer_channel #(
            .STABLE_CYCLES (STABLE_CYCLES)
`ifdef KEY_DEBOUNCER_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_channel (
            .clock       (clock),
            .reset_n     (reset_n),
            .key_n       (keys.key_n[i]),
            .key_level   (level[i]),
            .key_press   (press[i]),
            .key_release (release_p[i])
        );
    end

    assign keys.key_level   = level;
    assign keys.key_press   = press;
    assign keys.key_release = release_p;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer (STABLE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6).
// Expected pulse events are queued at stimulus time and popped by a negedge monitor.
module tb_key_debouncer;

    localparam int unsigned NK  = 4;
    localparam int unsigned LAT = 10;

    typedef struct {
        int unsigned   cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] level;
    } exp_t;

    logic        clock;
    logic        reset_n;
    int unsigned cyc;
    int unsigned passed;
    int unsigned total;
    exp_t        exp_q[$];

    key_debouncer_if #(.N_KEYS(NK)) ifc ();

    key_debouncer #(
        .N_KEYS        (NK),
        .STABLE_CYCLES (8),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (6)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .keys    (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic push(input int unsigned at, input logic [NK-1:0] p,
                        input logic [NK-1:0] r, input logic [NK-1:0] l);
        exp_t e;
        e.cyc = at; e.press = p; e.rel = r; e.level = l;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: every visible pulse must match the next queued event exactly.
    always @(negedge clock) begin
        exp_t e;
        if (ifc.key_press !== '0 || ifc.key_release !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: cycle %0d press=%b release=%b level=%b, expected no pulse",
                         cyc, ifc.key_press, ifc.key_release, ifc.key_level);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc == cyc && ifc.key_press === e.press && ifc.key_release === e.rel &&
                    ifc.key_level === e.level) begin
                    passed++;
                end else begin
                    $display("FAIL pulse_event: got cycle %0d press=%b release=%b level=%b, expected cycle %0d press=%b release=%b level=%b",
                             cyc, ifc.key_press, ifc.key_release, ifc.key_level,
                             e.cyc, e.press, e.rel, e.level);
                end
            end
        end
    end

    initial begin
        int unsigned c;
        int unsigned r;

        reset_n   = 1'b0;
        ifc.key_n = '1;
        wait_cycles(3);
        check("reset_level",   ifc.key_level,   '0);
        check("reset_press",   ifc.key_press,   '0);
        check("reset_release", ifc.key_release, '0);
        reset_n = 1'b1;
        wait_cycles(3);

        // Single press and release on key 0
        c = cyc;
        ifc.key_n[0] = 1'b0;
        push(c + LAT, 4'b0001, 4'b0000, 4'b0001);
        wait_cycles(15);
        check("k0_level_held", ifc.key_level, 4'b0001);
        c = cyc;
        ifc.key_n[0] = 1'b1;
        push(c + LAT, 4'b0000, 4'b0001, 4'b0000);
        wait_cycles(15);

        // Glitch train on key 1: 5 low, 2 high, 5 low
        ifc.key_n[1] = 1'b0; wait_cycles(5);
        ifc.key_n[1] = 1'b1; wait_cycles(2);
        ifc.key_n[1] = 1'b0; wait_cycles(5);
        ifc.key_n[1] = 1'b1; wait_cycles(15);
        check("glitch_level", ifc.key_level, 4'b0000);

        // One cycle short of STABLE_CYCLES: rejected
        ifc.key_n[1] = 1'b0; wait_cycles(7);
        ifc.key_n[1] = 1'b1; wait_cycles(15);
        check("short7_level", ifc.key_level, 4'b0000);

        // Exactly STABLE_CYCLES low: accepted, then released
        c = cyc;
        ifc.key_n[1] = 1'b0;
        push(c + LAT, 4'b0010, 4'b0000, 4'b0010);
        wait_cycles(8);
        c = cyc;
        ifc.key_n[1] = 1'b1;
        push(c + LAT, 4'b0000, 4'b0010, 4'b0000);
        wait_cycles(15);

        // All keys together, released 30 cycles later
        c = cyc;
        ifc.key_n = 4'b0000;
        push(c + LAT, 4'b1111, 4'b0000, 4'b1111);
`ifdef KEY_DEBOUNCER_REPEAT_EN
        push(c + LAT + 20, 4'b1111, 4'b0000, 4'b1111);
        push(c + LAT + 26, 4'b1111, 4'b0000, 4'b1111);
`endif
        wait_cycles(30);
        c = cyc;
        ifc.key_n = 4'b1111;
        push(c + LAT, 4'b0000, 4'b1111, 4'b0000);
        wait_cycles(15);
        check("all_released_level", ifc.key_level, 4'b0000);

        // Reset mid-debounce on key 2 while key 0 is already accepted
        c = cyc;
        ifc.key_n[0] = 1'b0;
        push(c + LAT, 4'b0001, 4'b0000, 4'b0001);
        wait_cycles(12);
        ifc.key_n[2] = 1'b0;
        wait_cycles(6);
        check("pre_reset_level", ifc.key_level, 4'b0001);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_level",   ifc.key_level,   '0);
        check("async_reset_press",   ifc.key_press,   '0);
        check("async_reset_release", ifc.key_release, '0);
        wait_cycles(3);
        r = cyc;
        reset_n = 1'b1;
        push(r + LAT, 4'b0101, 4'b0000, 4'b0101);
        wait_cycles(15);
        c = cyc;
        ifc.key_n = 4'b1111;
        push(c + LAT, 4'b0000, 4'b0101, 4'b0000);
        wait_cycles(15);

        // Key 3 held 50 cycles: repeats stop on the release edge
        c = cyc;
        ifc.key_n[3] = 1'b0;
        push(c + LAT, 4'b1000, 4'b0000, 4'b1000);
`ifdef KEY_DEBOUNCER_REPEAT_EN
        for (int unsigned k = 0; k < 5; k++)
            push(c + LAT + 20 + 6 * k, 4'b1000, 4'b0000, 4'b1000);
`endif
        wait_cycles(50);
        check("k3_level_held", ifc.key_level, 4'b1000);
        c = cyc;
        ifc.key_n[3] = 1'b1;
        push(c + LAT, 4'b0000, 4'b1000, 4'b0000);
        wait_cycles(20);

        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL missing_events: %0d expected events never seen, expected 0", exp_q.size());
        check("final_level", ifc.key_level, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent key channels.
REQ-002 Parameter STABLE_CYCLES, default 1_000_000: consecutive stable samples needed to accept a change (20 ms at 50 MHz); legal range 2..2^24.
REQ-003 Parameter REPEAT_DELAY, default 25_000_000: cycles a key is held before the first auto-repeat pulse; used only under REQ-024.
REQ-004 Parameter REPEAT_PERIOD, default 5_000_000: cycles between subsequent auto-repeat pulses; used only under REQ-024.
REQ-005 Port clock, input, 1: single clock for all logic.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port key_n, input, N_KEYS: raw asynchronous push-button inputs; 0 means pressed.
REQ-008 Port key_level, output, N_KEYS: debounced state; 1 means pressed.
REQ-009 Port key_press, output, N_KEYS: one-cycle pulse per accepted press, and per auto-repeat event when enabled.
REQ-010 Port key_release, output, N_KEYS: one-cycle pulse per accepted release.

Function
REQ-011 Each key_n bit SHALL pass through a two-flop synchronizer, then be inverted to active-high "sample".
REQ-012 Each channel SHALL hold a counter of width $clog2(STABLE_CYCLES).
- sample == key_level: counter cleared.
- sample != key_level and counter < STABLE_CYCLES-1: counter incremented.
- sample != key_level and counter == STABLE_CYCLES-1: key_level <= sample, counter cleared.
REQ-013 A raw change held steady SHALL reach key_level exactly 2+STABLE_CYCLES clock edges after the first edge that samples it.
REQ-014 Any glitch shorter than STABLE_CYCLES sampled cycles SHALL clear the counter and leave key_level unchanged.
REQ-015 key_press SHALL be 1 for exactly the one cycle in which key_level first reads 1 after a 0→1 update; key_release likewise for 1→0.
REQ-016 key_press and key_release of a channel SHALL never be asserted in the same cycle.
REQ-017 All outputs SHALL be registered, with no combinational path from key_n.
REQ-018 Channels SHALL be fully independent; simultaneous changes on several keys produce simultaneous pulses.
REQ-019 The counter SHALL saturate and never wrap; its width SHALL hold STABLE_CYCLES-1 without overflow.

Reset
REQ-020 While reset_n is 0, synchronizer flops SHALL be 1 (idle, released), and counters, key_level, key_press and key_release SHALL be 0.
REQ-021 Reset SHALL take effect asynchronously, including mid-debounce; no press or release pulse SHALL be emitted as a result of reset assertion or deassertion.
REQ-022 A key held down through reset deassertion SHALL produce one key_press exactly 2+STABLE_CYCLES cycles after release of reset.

Configuration
REQ-023 Without macro KEY_DEBOUNCER_REPEAT_EN, the block SHALL contain no repeat logic, and key_press SHALL occur only per REQ-015.
REQ-024 With KEY_DEBOUNCER_REPEAT_EN defined, each channel SHALL add a repeat counter cleared on any key_level change.
- While key_level is 1, an extra key_press pulse SHALL be emitted REQ_DELAY = REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles.
- Repeat pulses SHALL stop in the cycle key_level drops; key_release behaviour is unchanged.

Structure
REQ-025 A shared package key_debouncer_pkg SHALL hold default constants (STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD defaults for a 50 MHz clock) and a cycles-from-milliseconds helper function.
REQ-026 Per-key logic (synchronizer, counter, edge pulses, optional repeat) SHALL live in sub-module key_debouncer_channel, instantiated N_KEYS times by a generate loop.

Verification (bench uses STABLE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6)
REQ-027 key_n[0] driven 1→0 and held -> key_level[0]=1 and a single key_press[0] pulse exactly 10 edges later; other bits stay 0.
REQ-028 key_n[1] toggled low for 5 cycles, high for 2, low for 5 -> no change on key_level[1] and no pulses.
REQ-029 All four keys pressed on the same edge, then released 30 cycles later -> four simultaneous press pulses, then four simultaneous release pulses, each 10 edges after its stimulus.
REQ-030 reset_n pulsed low while key_n[2] has been low for 6 cycles -> all outputs 0 immediately; after reset, key_press[2] occurs 10 edges after reset deassertion.
REQ-031 With KEY_DEBOUNCER_REPEAT_EN defined, key 3 held for 50 cycles -> key_press[3] pulses at press+0, +20, +26, +32, +38 and +44, then one key_release[3]; without the macro, only the initial pulse.
